cache_arbiter: RTL and testbench

Two-requester arbiter that shares the single `req`/`resp` port of the `cache` block between the core's instruction-fetch port (`if_`) and data-memory port (`dm_`). It sits between the core and `cache`. It selects one pending request per cycle and holds that selection stable until the cache accepts it. It records the owner of every accepted request in an in-order owner FIFO, so each cache response goes back to the requester that issued it.

---
 rtl/cache_arbiter.sv | 118 +++++++++++
 tb/tb_cache_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-requester (if/dm) arbiter in front of the single cache req/resp port, with an
// in-order owner FIFO for response routing. Define CACHE_ARB_RR_EN for round-robin on conflict.
module cache_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_valid_i,
    input  logic [31:0] if_req_value_i,
    input  logic [31:0] if_req_addr_i,
    input  logic [3:0]  if_req_wstrb_i,
    output logic        if_req_ready_o,
    output logic        if_resp_valid_o,
    output logic [31:0] if_resp_value_o,
    input  logic        dm_req_valid_i,
    input  logic [31:0] dm_req_value_i,
    input  logic [31:0] dm_req_addr_i,
    input  logic [3:0]  dm_req_wstrb_i,
    output logic        dm_req_ready_o,
    output logic        dm_resp_valid_o,
    output logic [31:0] dm_resp_value_o,
    output logic        m_req_valid_o,
    output logic [31:0] m_req_value_o,
    output logic [31:0] m_req_addr_o,
    output logic [3:0]  m_req_wstrb_o,
    input  logic        m_req_ready_i,
    input  logic        m_resp_valid_i,
    input  logic [31:0] m_resp_value_i,
    output logic        err_o
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [MAX_OUT-1:0] r_fifo;
    logic [PW-1:0]      r_wptr, r_rptr;
    logic [CW-1:0]      r_cnt;
    logic               r_lock, r_lock_sel, r_last, r_err;

    logic w_full, w_empty, w_any, w_sel, w_push, w_pop, w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_cnt == CW'(MAX_OUT));
    assign w_empty = (r_cnt == '0);
    assign w_any   = if_req_valid_i | dm_req_valid_i;

    // sel: 0 = if, 1 = dm
    always_comb begin
        w_sel = dm_req_valid_i;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (if_req_valid_i && dm_req_valid_i) begin
`ifdef CACHE_ARB_RR_EN
            w_sel = ~r_last;
`else
            w_sel = 1'b1;
`endif
        end
    end

`ifndef CACHE_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = r_last;
`endif

    assign m_req_valid_o = rst_ni & w_any & ~w_full;
    assign m_req_addr_o  = w_sel ? dm_req_addr_i  : if_req_addr_i;
    assign m_req_value_o = w_sel ? dm_req_value_i : if_req_value_i;
    assign m_req_wstrb_o = w_sel ? dm_req_wstrb_i : if_req_wstrb_i;

    // readies use the registered count only, so a same-cycle pop never frees a slot
    assign if_req_ready_o = rst_ni & ~w_sel & m_req_ready_i & ~w_full;
    assign dm_req_ready_o = rst_ni &  w_sel & m_req_ready_i & ~w_full;

    assign w_push = m_req_valid_o & m_req_ready_i;
    assign w_pop  = m_resp_valid_i & ~w_empty;
    assign w_head = r_fifo[r_rptr];

    assign if_resp_valid_o = rst_ni & w_pop & ~w_head;
    assign dm_resp_valid_o = rst_ni & w_pop &  w_head;
    assign if_resp_value_o = m_resp_value_i;
    assign dm_resp_value_o = m_resp_value_i;
    assign err_o           = rst_ni & r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= ptr_inc(r_wptr);
                r_last         <= w_sel;
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_push) begin
                r_lock <= 1'b0;
            end else if (m_req_valid_o && !m_req_ready_i) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_sel;
            end
            if (m_resp_valid_i && w_empty) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: directed scenarios plus a random phase,
// all checked against a queue-based owner model.
module tb_cache_arbiter;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_v = 1'b0, dm_v = 1'b0;
    logic [31:0] if_d = '0, if_a = '0, dm_d = '0, dm_a = '0;
    logic [3:0]  if_w = '0, dm_w = '0;
    logic        m_ready = 1'b0, resp_v = 1'b0;
    logic [31:0] resp_d = '0;
    logic        if_rdy, dm_rdy, if_rv, dm_rv, m_v, err;
    logic [31:0] if_rd, dm_rd, m_d, m_a;
    logic [3:0]  m_w;

    cache_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_valid_i(if_v), .if_req_value_i(if_d), .if_req_addr_i(if_a), .if_req_wstrb_i(if_w),
        .if_req_ready_o(if_rdy), .if_resp_valid_o(if_rv), .if_resp_value_o(if_rd),
        .dm_req_valid_i(dm_v), .dm_req_value_i(dm_d), .dm_req_addr_i(dm_a), .dm_req_wstrb_i(dm_w),
        .dm_req_ready_o(dm_rdy), .dm_resp_valid_o(dm_rv), .dm_resp_value_o(dm_rd),
        .m_req_valid_o(m_v), .m_req_value_o(m_d), .m_req_addr_o(m_a), .m_req_wstrb_o(m_w),
        .m_req_ready_i(m_ready), .m_resp_valid_i(resp_v), .m_resp_value_i(resp_d),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: owner queue plus grant lock / history
    bit owners[$];
    bit md_lock, md_lock_sel, md_last, md_err;
    bit acc_if, acc_dm;

    task automatic step();
        bit full, sel, mv, pop, owner;
        #1;
        full = (owners.size() == MAX_OUT);
        if (md_lock)            sel = md_lock_sel;
        else if (if_v && dm_v)
`ifdef CACHE_ARB_RR_EN
                                sel = !md_last;
`else
                                sel = 1'b1;
`endif
        else                    sel = dm_v;
        mv = (if_v || dm_v) && !full;
        chk("m_valid", 32'(m_v), 32'(mv));
        if (mv) begin
            chk("m_addr",  m_a, sel ? dm_a : if_a);
            chk("m_value", m_d, sel ? dm_d : if_d);
            chk("m_wstrb", 32'(m_w), 32'(sel ? dm_w : if_w));
        end
        chk("if_ready", 32'(if_rdy), 32'(!sel && m_ready && !full));
        chk("dm_ready", 32'(dm_rdy), 32'(sel && m_ready && !full));
        pop   = resp_v && (owners.size() != 0);
        owner = pop ? owners[0] : 1'b0;
        chk("if_resp_v", 32'(if_rv), 32'(pop && !owner));
        chk("dm_resp_v", 32'(dm_rv), 32'(pop && owner));
        if (pop) chk("resp_val", owner ? dm_rd : if_rd, resp_d);
        chk("err", 32'(err), 32'(md_err));
        // model update for the coming rising edge
        acc_if = mv && m_ready && !sel;
        acc_dm = mv && m_ready && sel;
        if (resp_v && owners.size() == 0) md_err = 1'b1;
        if (pop) void'(owners.pop_front());
        if (mv && m_ready) begin
            owners.push_back(sel);
            md_last = sel;
            md_lock = 1'b0;
        end else if (mv) begin
            md_lock     = 1'b1;
            md_lock_sel = sel;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_v = 1'b1; dm_v = 1'b1; m_ready = 1'b1; resp_v = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_v), 32'd0);
        chk("rst_ready", 32'({if_rdy, dm_rdy}), 32'd0);
        chk("rst_resp_v", 32'({if_rv, dm_rv}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; if_v = 1'b0; dm_v = 1'b0; m_ready = 1'b0; resp_v = 1'b0;
        owners.delete();
        md_lock = 1'b0; md_lock_sel = 1'b0; md_last = 1'b0; md_err = 1'b0;
        acc_if = 1'b0; acc_dm = 1'b0;
    endtask

    initial begin
        do_reset();

        // single fetch
        if_v = 1'b1; if_a = 32'h100; if_w = 4'h0; if_d = 32'h0; m_ready = 1'b1;
        #1 chk("fetch_addr", m_a, 32'h100);
        step();
        if_v = 1'b0;
        step();
        resp_v = 1'b1; resp_d = 32'hDEADBEEF;
        #1;
        chk("fetch_if_rv", 32'(if_rv), 32'd1);
        chk("fetch_dm_rv", 32'(dm_rv), 32'd0);
        chk("fetch_data", if_rd, 32'hDEADBEEF);
        step();
        resp_v = 1'b0;
        step();

`ifndef CACHE_ARB_RR_EN
        // fixed-priority conflict
        do_reset();
        if_v = 1'b1; if_a = 32'h200; if_w = 4'h0;
        dm_v = 1'b1; dm_a = 32'h300; dm_w = 4'hF; dm_d = 32'h12345678; m_ready = 1'b1;
        #1;
        chk("fp_dm_first", 32'(dm_rdy), 32'd1);
        chk("fp_addr1", m_a, 32'h300);
        step();
        dm_v = 1'b0;
        #1;
        chk("fp_if_second", 32'(if_rdy), 32'd1);
        chk("fp_addr2", m_a, 32'h200);
        step();
        if_v = 1'b0; resp_v = 1'b1; resp_d = 32'hAAAA0001;
        #1 chk("fp_r1_dm", 32'(dm_rv), 32'd1);
        step();
        resp_d = 32'hAAAA0002;
        #1 chk("fp_r2_if", 32'(if_rv), 32'd1);
        step();
        resp_v = 1'b0;
        step();
`else
        // round-robin: dm, if, dm, if
        do_reset();
        if_v = 1'b1; dm_v = 1'b1; m_ready = 1'b1; if_a = 32'h10; dm_a = 32'h20;
        for (int k = 0; k < 4; k++) begin
            resp_v = (k != 0); resp_d = 32'(k);
            #1 chk("rr_grant_dm", 32'(dm_rdy), 32'((k % 2) == 0));
            step();
        end
        if_v = 1'b0; dm_v = 1'b0; resp_v = 1'b1;
        step();
        resp_v = 1'b0;
        step();
`endif

        // lock holds the stalled if request
        do_reset();
        if_v = 1'b1; if_a = 32'h400; m_ready = 1'b0; dm_a = 32'h500; dm_w = 4'h3;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) dm_v = 1'b1;
            #1 chk("lock_addr", m_a, 32'h400);
            step();
        end
        m_ready = 1'b1;
        #1;
        chk("lock_rel_addr", m_a, 32'h400);
        chk("lock_rel_if_rdy", 32'(if_rdy), 32'd1);
        step();
        if_v = 1'b0;
        #1 chk("lock_dm_after", 32'(dm_rdy), 32'd1);
        step();
        dm_v = 1'b0; resp_v = 1'b1;
        step(); step();
        resp_v = 1'b0;

        // full FIFO
        do_reset();
        if_v = 1'b1; if_a = 32'h600; m_ready = 1'b1;
        step();
        if_a = 32'h604;
        step();
        if_a = 32'h608;
        #1 chk("full_block", 32'({m_v, if_rdy, dm_rdy}), 32'd0);
        step();
        resp_v = 1'b1; resp_d = 32'h55;
        #1 chk("full_pop_cycle", 32'(m_v), 32'd0);
        step();
        resp_v = 1'b0;
        #1 chk("full_resume", 32'({m_v, if_rdy}), 32'b11);
        step();
        if_v = 1'b0; resp_v = 1'b1;
        step(); step();
        resp_v = 1'b0;

        // spurious response
        do_reset();
        resp_v = 1'b1; resp_d = 32'hBAD;
        #1 chk("spur_no_rv", 32'({if_rv, dm_rv}), 32'd0);
        step();
        resp_v = 1'b0;
        #1 chk("spur_err", 32'(err), 32'd1);
        step(); step();
        #1 chk("spur_sticky", 32'(err), 32'd1);
        do_reset();

        // random phase, with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            if (!if_v && ($urandom % 2 == 0)) begin
                if_v = 1'b1; if_a = $urandom; if_d = $urandom; if_w = 4'($urandom_range(0, 15));
            end
            if (!dm_v && ($urandom % 2 == 0)) begin
                dm_v = 1'b1; dm_a = $urandom; dm_d = $urandom; dm_w = 4'($urandom_range(0, 15));
            end
            m_ready = ($urandom % 4) != 0;
            resp_v  = (owners.size() != 0) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
            resp_d  = $urandom;
            step();
            if (acc_if) if_v = 1'b0;
            if (acc_dm) dm_v = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
